// File: rtl/keycode_entry.sv
// -----------------------------------------------------------------------------
// keycode_entry
//
// Receiving end of the 16-button priority-encoder keypad path. The encoded key
// number and its "any key" strobe arrive asynchronously to hz100. They are
// brought into the clock domain through two flops each, then debounced. The
// block emits exactly one event per physical press. Each event is decoded to a
// one-hot key vector and shifted into an NDIGITS hex-digit entry register that
// drives the seven-segment decoders, one nibble per display.
//
// Handshake: key_valid is a one-cycle, valid-only pulse with no ready or
// backpressure. key_onehot is qualified by key_valid and is zero otherwise.
// digits and ndigits already include the new key in the same cycle that
// key_valid is high.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synced samples needed to accept a
//                    press or a release (>= 2)
//   NDIGITS          hex digits held in the entry register (1..8)
//
// Ports
//   hz100       in   1                    system clock
//   reset       in   1                    synchronous, active-low reset
//   code        in   4                    encoded key number, asynchronous
//   strobe      in   1                    any key pressed, asynchronous
//   clr         in   1                    synchronous clear of the entry register
//   key_valid   out  1                    one-cycle pulse per accepted press
//   key_onehot  out  16                   1<<key while key_valid, else 0
//   key_down    out  1                    high while an accepted key is held
//   digits      out  4*NDIGITS            entry register, newest digit in [3:0]
//   ndigits     out  clog2(NDIGITS+1)     digits entered, saturates at NDIGITS
// -----------------------------------------------------------------------------
module keycode_entry #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int NDIGITS         = 8
) (
  input  logic                           hz100,
  input  logic                           reset,
  input  logic [3:0]                     code,
  input  logic                           strobe,
  input  logic                           clr,
  output logic                           key_valid,
  output logic [15:0]                    key_onehot,
  output logic                           key_down,
  output logic [4*NDIGITS-1:0]           digits,
  output logic [$clog2(NDIGITS+1)-1:0]   ndigits
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ND_W  = $clog2(NDIGITS + 1);
  localparam int DIG_W = 4 * NDIGITS;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ND_W-1:0]  ND_ONE   = ND_W'(1);
  localparam logic [ND_W-1:0]  ND_FULL  = ND_W'(NDIGITS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. The code bus can be caught mid-change, so a torn
  // value may appear for one sample. The debouncer only accepts a code after it
  // has been stable for DEBOUNCE_CYCLES samples, which filters that out.
  // ---------------------------------------------------------------------------
  logic [3:0] code_s1, s_code;
  logic       strobe_s1, s_strobe;

  always_ff @(posedge hz100) begin
    if (!reset) begin
      code_s1   <= '0;
      s_code    <= '0;
      strobe_s1 <= 1'b0;
      s_strobe  <= 1'b0;
    end else begin
      code_s1   <= code;
      s_code    <= code_s1;
      strobe_s1 <= strobe;
      s_strobe  <= strobe_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t           state, state_n;
  logic [3:0]       lat_code, lat_code_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fire;

  always_ff @(posedge hz100) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_code <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat_code <= lat_code_n;
    end
  end

  // The sample that moves IDLE to PRESS_WAIT counts as the first stable
  // sample. The event therefore fires on the DEBOUNCE_CYCLES-th consecutive
  // identical pressed sample. Release works the same way: the sample that
  // moves HELD to RELEASE_WAIT counts as the first released sample.
  always_comb begin
    state_n    = state;
    lat_code_n = lat_code;
    cnt_n      = cnt;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_strobe) begin
          state_n    = PRESS_WAIT;
          lat_code_n = s_code;
          cnt_n      = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s_strobe) begin
          state_n = IDLE;
        end else if (s_code != lat_code) begin
          lat_code_n = s_code;
          cnt_n      = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          fire    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_strobe) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end else if (s_code != lat_code) begin
          // A higher-priority key rolled over the held one. Debounce it as a
          // fresh press.
          state_n    = PRESS_WAIT;
          lat_code_n = s_code;
          cnt_n      = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s_strobe) begin
          if (s_code == lat_code) begin
            // Release bounce on the same key: resume holding with no new event.
            state_n = HELD;
          end else begin
            state_n    = PRESS_WAIT;
            lat_code_n = s_code;
            cnt_n      = CNT_ONE;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry register candidates. A single-digit register has nothing to shift,
  // so it simply takes the new key.
  // ---------------------------------------------------------------------------
  logic [DIG_W-1:0] digits_shift;
  logic [DIG_W-1:0] digits_lat;

  assign digits_lat = DIG_W'(lat_code);

  if (NDIGITS == 1) begin : g_single_digit
    assign digits_shift = digits_lat;
  end else begin : g_multi_digit
    assign digits_shift = {digits[DIG_W-5:0], lat_code};
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. Every output is a flop, so there is no combinational
  // path from code, strobe or clr to any output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge hz100) begin
    if (!reset) begin
      key_valid  <= 1'b0;
      key_onehot <= '0;
      key_down   <= 1'b0;
      digits     <= '0;
      ndigits    <= '0;
    end else begin
      key_valid  <= fire;
      key_onehot <= fire ? (16'h0001 << lat_code) : 16'h0000;
      key_down   <= (state_n == HELD) || (state_n == RELEASE_WAIT);

      // clr wins over the existing contents but still keeps a key accepted
      // on the same edge. The user sees that key as the first new digit.
      if (clr) begin
        digits  <= fire ? digits_lat : '0;
        ndigits <= fire ? ND_ONE : '0;
      end else if (fire) begin
        digits <= digits_shift;
        if (ndigits != ND_FULL) begin
          ndigits <= ndigits + ND_ONE;
        end
      end
    end
  end

endmodule
